fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch for the IF stage: owns the PC, arbitrates next-PC sources and runs the req/gnt/rvalid handshake to instruction memory.
//  Next-PC sources, highest priority first: branch, jump, sequential (+4), hold (stall).
//  Sits between the ID/EX redirect logic and a variable-latency instruction memory. Drives the IF/ID payload: if_valid, if_pc, if_npc, if_instr.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; first address fetched.
// PORTS
//  clk         in   1   clock; all state updates on posedge.
//  rst         in   1   synchronous, active-high reset.
//  stall       in   1   ID hazard; hold the current IF/ID payload.
//  br_taken    in   1   branch resolved taken this cycle.
//  br_target   in   32  branch target address.
//  jmp_valid   in   1   jump decoded this cycle.
//  jmp_target  in   32  jump target address.
//  imem_req    out  1   fetch request.
//  imem_addr   out  32  fetch address (= pc).
//  imem_gnt    in   1   request accepted this cycle.
//  imem_rvalid in   1   response data valid.
//  imem_rdata  in   32  response instruction word.
//  if_valid    out  1   IF/ID payload holds a live instruction.
//  if_pc       out  32  address of if_instr.
//  if_npc      out  32  if_pc + 4, mod 2^32.
//  if_instr    out  32  fetched instruction.
//  busy        out  1   a request is outstanding (state != FETCH).
// BEHAVIOUR
//  Reset values: state=FETCH, pc=RESET_PC, if_valid=0, if_instr=32'h0 (NOP), if_pc=RESET_PC, if_npc=RESET_PC+4.
//  Reset during operation discards any in-flight response.
//  Redirect: redir = br_taken | jmp_valid; target = br_taken ? br_target : jmp_target.
//   target[1:0] is forced to 2'b00 when loaded into pc.
//  A redirect clears if_valid on the next edge and overrides stall.
//  A consume happens in any cycle with if_valid=1, stall=0 and no redirect; it clears if_valid on the next edge.
//  imem_req = (state==FETCH) & ~(if_valid & stall) & ~rst. imem_addr = pc.
//  imem_addr may change only while imem_gnt=0.
//  At most one request is outstanding. Responses arrive in order, at least 1 cycle after gnt.
//  FETCH:
//   - redir & gnt -> DRAIN, pc<=target.
//   - redir & ~gnt -> stay FETCH, pc<=target.
//   - gnt -> WAIT.
//   - otherwise stay FETCH.
//   - imem_rvalid is ignored in FETCH.
//  WAIT:
//   - redir -> pc<=target; if rvalid is high the same cycle, drop it and go to FETCH; else go to DRAIN.
//   - rvalid & ~redir -> capture: if_instr<=rdata, if_pc<=pc, if_npc<=pc+4, if_valid<=1, pc<=pc+4; go to FETCH.
//  DRAIN:
//   - rvalid -> discard the data, go to FETCH.
//   - redir -> pc<=target (the later redirect wins); stay in DRAIN unless rvalid is also high.
//  Output register invariant: it is empty or being consumed whenever a request issues, so a capture never overwrites a live instruction.
//  Best-case throughput: one instruction per 2 cycles (gnt, then rvalid on the next cycle).
//  Arithmetic is 32-bit unsigned and wraps: pc 32'hFFFF_FFFC + 4 -> 32'h0.
// STRUCTURE
//  Package fetch_pkg:
//   - state encoding: FETCH=2'd0, WAIT=2'd1, DRAIN=2'd2.
//   - constants: NOP_INSTR=32'h0, PC_INC=32'd4.
//  Sub-module fetch_redirect_mux: combinational priority select producing redir and target (aligned).
//  Top level holds the FSM, the pc register and the IF/ID output registers.
// TESTING
//  1. Reset, then gnt on each request with rvalid 1 cycle later
//     -> addrs 0x0, 0x4, 0x8; if_pc tracks; if_valid toggles every 2 cycles.
//  2. stall=1 while if_valid=1 -> imem_req=0 and payload stable; release stall -> next fetch issues the following cycle.
//  3. br_taken=1 and jmp_valid=1 in the same cycle (br_target=0x100, jmp_target=0x200)
//     -> next imem_addr=0x100; if_valid=0.
//  4. Redirect to 0x40 in WAIT, rvalid 3 cycles later -> the rdata is discarded (if_valid stays 0); the next request addr is 0x40.
//  5. Redirect with target 0x43 during FETCH while gnt=0 -> imem_addr becomes 0x40 next cycle; no DRAIN entered.
//  6. rst asserted in WAIT, then rvalid arrives -> response ignored, if_valid=0, first request after reset is at RESET_PC.
//  7. pc=0xFFFF_FFFC capture -> if_npc=0x0; next request addr is 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_mux.sv
// Priority select of the redirect source: a taken branch beats a jump.
module fetch_redirect_mux
    import fetch_pkg::*;
(
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_valid_i,
    input  logic [31:0] jmp_target_i,
    output logic        redir_o,
    output logic [31:0] target_o
);

    assign redir_o  = br_taken_i | jmp_valid_i;
    assign target_o = align_word(br_taken_i ? br_target_i : jmp_target_i);

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the PC, runs the imem req/gnt/rvalid
// handshake and holds the IF/ID payload registers.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_npc,
    output logic [31:0] if_instr,
    output logic        busy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_npc_q, if_npc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic         redir;
    logic [31:0]  target;
    logic         capture;
    logic         accepted;

    fetch_redirect_mux u_redirect_mux (
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .jmp_valid_i  (jmp_valid),
        .jmp_target_i (jmp_target),
        .redir_o      (redir),
        .target_o     (target)
    );

    // A live payload under stall blocks issue, so a capture never clobbers it.
    assign imem_req  = (state_q == FETCH) & ~(if_valid_q & stall) & ~rst;
    assign imem_addr = pc_q;
    assign accepted  = imem_req & imem_gnt;
    assign busy      = (state_q != FETCH);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        case (state_q)
            FETCH: begin
                if (redir) begin
                    pc_d = target;
                    if (accepted) state_d = DRAIN;
                end else if (accepted) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redir) begin
                    pc_d    = target;
                    state_d = imem_rvalid ? FETCH : DRAIN;
                end else if (imem_rvalid) begin
                    capture = 1'b1;
                    pc_d    = pc_q + PC_INC;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redir) pc_d = target;
                if (imem_rvalid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_npc_d   = if_npc_q;
        if_instr_d = if_instr_q;
        if (capture) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_npc_d   = pc_q + PC_INC;
            if_instr_d = imem_rdata;
        end else if (redir || (if_valid_q && !stall)) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= RESET_PC;
            if_npc_q   <= RESET_PC + PC_INC;
            if_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_npc_q   <= if_npc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_npc   = if_npc_q;
    assign if_instr = if_instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand corner sequences,
// then random traffic against a transaction-level reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst, stall, br_taken, jmp_valid, imem_gnt, imem_rvalid;
    logic [31:0] br_target, jmp_target, imem_rdata;
    logic        imem_req, if_valid, busy;
    logic [31:0] imem_addr, if_pc, if_npc, if_instr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_npc     (if_npc),
        .if_instr   (if_instr),
        .busy       (busy)
    );

    typedef struct {
        logic        rst, stall, br, jmp, gnt, rv;
        logic [31:0] bt, jt, rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc, e_instr;
        logic        e_busy;
    } vec_t;

    vec_t tv[20];

    function automatic vec_t mk(input logic r, s, b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt,
                                input logic g, v, input logic [31:0] d,
                                input logic eq, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep, ei,
                                input logic eb);
        vec_t t;
        t.rst = r; t.stall = s; t.br = b; t.bt = bt; t.jmp = j; t.jt = jt;
        t.gnt = g; t.rv = v; t.rd = d;
        t.e_req = eq; t.e_addr = ea; t.e_v = ev; t.e_pc = ep; t.e_instr = ei;
        t.e_busy = eb;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, s, b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt,
                         input logic g, v, input logic [31:0] d);
        @(negedge clk);
        rst = r; stall = s; br_taken = b; br_target = bt; jmp_valid = j;
        jmp_target = jt; imem_gnt = g; imem_rvalid = v; imem_rdata = d;
        #1;
    endtask

    // Reference model state: a pending-fetch record plus the visible payload.
    logic [31:0] m_pc, m_paddr, m_ipc, m_npc, m_instr;
    logic        m_pend, m_plive, m_v;

    task automatic model_reset();
        m_pc = 32'h0; m_pend = 1'b0; m_plive = 1'b0; m_v = 1'b0;
        m_ipc = 32'h0; m_npc = 32'h4; m_instr = 32'h0;
    endtask

    initial begin
        logic        r, s, b, j, g, v, exp_req, red, cap;
        logic [31:0] bt, jt, d, tgt, old_pc;

        tv[0]  = mk(1,0,0,0,0,0,0,0,0,              0,32'h0,0,32'h0,32'h0,0);
        tv[1]  = mk(0,0,0,0,0,0,1,0,0,              1,32'h0,0,32'h0,32'h0,0);
        tv[2]  = mk(0,0,0,0,0,0,0,1,32'hA0,         0,32'h0,0,32'h0,32'h0,1);
        tv[3]  = mk(0,0,0,0,0,0,1,0,0,              1,32'h4,1,32'h0,32'hA0,0);
        tv[4]  = mk(0,0,0,0,0,0,0,1,32'hA1,         0,32'h4,0,32'h0,32'hA0,1);
        tv[5]  = mk(0,1,0,0,0,0,0,0,0,              0,32'h8,1,32'h4,32'hA1,0);
        tv[6]  = mk(0,1,0,0,0,0,0,0,0,              0,32'h8,1,32'h4,32'hA1,0);
        tv[7]  = mk(0,0,0,0,0,0,1,0,0,              1,32'h8,1,32'h4,32'hA1,0);
        tv[8]  = mk(0,0,0,0,0,0,0,1,32'hA2,         0,32'h8,0,32'h4,32'hA1,1);
        tv[9]  = mk(0,0,1,32'h100,1,32'h200,0,0,0,  1,32'hC,1,32'h8,32'hA2,0);
        tv[10] = mk(0,0,0,0,0,0,1,0,0,              1,32'h100,0,32'h8,32'hA2,0);
        tv[11] = mk(0,0,0,0,1,32'h40,0,0,0,         0,32'h100,0,32'h8,32'hA2,1);
        tv[12] = mk(0,0,0,0,0,0,0,0,0,              0,32'h40,0,32'h8,32'hA2,1);
        tv[13] = mk(0,0,0,0,0,0,0,0,0,              0,32'h40,0,32'h8,32'hA2,1);
        tv[14] = mk(0,0,0,0,0,0,0,1,32'hDEAD,       0,32'h40,0,32'h8,32'hA2,1);
        tv[15] = mk(0,0,1,32'h83,0,0,0,0,0,         1,32'h40,0,32'h8,32'hA2,0);
        tv[16] = mk(0,0,0,0,0,0,0,0,0,              1,32'h80,0,32'h8,32'hA2,0);
        tv[17] = mk(0,0,0,0,0,0,1,0,0,              1,32'h80,0,32'h8,32'hA2,0);
        tv[18] = mk(0,0,0,0,0,0,0,1,32'hA3,         0,32'h80,0,32'h8,32'hA2,1);
        tv[19] = mk(0,1,0,0,0,0,0,0,0,              0,32'h84,1,32'h80,32'hA3,0);

        drive(1,0,0,0,0,0,0,0,0);
        for (int i = 0; i < 20; i++) begin
            drive(tv[i].rst, tv[i].stall, tv[i].br, tv[i].bt, tv[i].jmp, tv[i].jt,
                  tv[i].gnt, tv[i].rv, tv[i].rd);
            chk($sformatf("v%0d.req", i),   {31'b0, imem_req}, {31'b0, tv[i].e_req});
            chk($sformatf("v%0d.addr", i),  imem_addr,         tv[i].e_addr);
            chk($sformatf("v%0d.valid", i), {31'b0, if_valid}, {31'b0, tv[i].e_v});
            chk($sformatf("v%0d.pc", i),    if_pc,             tv[i].e_pc);
            chk($sformatf("v%0d.instr", i), if_instr,          tv[i].e_instr);
            chk($sformatf("v%0d.busy", i),  {31'b0, busy},     {31'b0, tv[i].e_busy});
        end
        chk("v_end.npc", if_npc, 32'h84);

        // Reset while a response is outstanding; the late response must be ignored.
        drive(1,0,0,0,0,0,0,0,0);
        drive(0,0,0,0,0,0,1,0,0);
        chk("rstwait.req", {31'b0, imem_req}, 32'h1);
        drive(1,0,0,0,0,0,0,0,0);
        chk("rstwait.busy", {31'b0, busy}, 32'h1);
        drive(0,0,0,0,0,0,0,1,32'hBAD0);
        chk("rstwait.req2", {31'b0, imem_req}, 32'h1);
        chk("rstwait.addr", imem_addr, 32'h0);
        drive(0,0,0,0,0,0,0,0,0);
        chk("rstwait.valid", {31'b0, if_valid}, 32'h0);
        chk("rstwait.instr", if_instr, 32'h0);
        chk("rstwait.npc", if_npc, 32'h4);

        // Capture at the top of the address space wraps npc and pc.
        drive(1,0,0,0,0,0,0,0,0);
        drive(0,0,1,32'hFFFF_FFFF,0,0,0,0,0);
        drive(0,0,0,0,0,0,1,0,0);
        chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        drive(0,0,0,0,0,0,0,1,32'h1234);
        drive(0,0,0,0,0,0,0,0,0);
        chk("wrap.valid", {31'b0, if_valid}, 32'h1);
        chk("wrap.pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap.npc", if_npc, 32'h0);
        chk("wrap.addr2", imem_addr, 32'h0);
        chk("wrap.instr", if_instr, 32'h1234);

        // Random traffic against the reference model.
        drive(1,0,0,0,0,0,0,0,0);
        @(posedge clk);
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(63) == 0);
            s  = ($urandom_range(3) == 0);
            b  = ($urandom_range(7) == 0);
            j  = ($urandom_range(7) == 0);
            bt = $urandom; jt = $urandom; d = $urandom;
            g  = $urandom_range(1);
            v  = m_pend && ($urandom_range(2) == 0);
            drive(r, s, b, bt, j, jt, g, v, d);
            exp_req = !m_pend && !(m_v && s) && !r;
            chk("rnd.req",   {31'b0, imem_req}, {31'b0, exp_req});
            chk("rnd.addr",  imem_addr,         m_pc);
            chk("rnd.busy",  {31'b0, busy},     {31'b0, m_pend});
            chk("rnd.valid", {31'b0, if_valid}, {31'b0, m_v});
            chk("rnd.pc",    if_pc,             m_ipc);
            chk("rnd.npc",   if_npc,            m_npc);
            chk("rnd.instr", if_instr,          m_instr);
            @(posedge clk);
            if (r) begin
                model_reset();
            end else begin
                red    = b | j;
                tgt    = (b ? bt : jt) & 32'hFFFF_FFFC;
                old_pc = m_pc;
                cap    = 1'b0;
                if (m_pend && v) begin
                    m_pend = 1'b0;
                    if (m_plive && !red) begin
                        cap = 1'b1;
                        m_v = 1'b1; m_ipc = m_paddr; m_npc = m_paddr + 32'd4;
                        m_instr = d; m_pc = m_paddr + 32'd4;
                    end
                end
                if (!cap && (red || !s)) m_v = 1'b0;
                if (red) begin
                    m_plive = 1'b0;
                    m_pc = tgt;
                end
                if (exp_req && g) begin
                    m_pend = 1'b1; m_paddr = old_pc; m_plive = !red;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
